// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, synchronizes the asynchronous LOCK
// input, waits for a stable lock before releasing the design reset, retries on
// lock timeout and re-holds the design reset whenever lock is lost in RUN.
// Runs on the free-running board clock, never on a PLL output.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               pll_locked,
    output logic                               pll_rst,
    output logic                               sys_rst,
    output logic                               ready,
    output logic                               fail,
    output logic [7:0]                         lock_loss_count,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

    // Largest interval the cycle counter has to cover; the counter only ever
    // reaches (interval - 1) because it is cleared on every state change.
    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam int RW      = $clog2(MAX_RETRIES+1);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   lock_s;
    state_t                 state_r;
    state_t                 state_nx_s;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_nx_s;
    logic [RW-1:0]          retry_r;
    logic [7:0]             loss_r;
    logic                   retry_inc_s;
    logic                   loss_inc_s;
    logic                   pll_rst_r;
    logic                   sys_rst_r;
    logic                   ready_r;
    logic                   fail_r;

    // Every decision below uses only the last synchronizer stage.
    assign lock_s = sync_r[SYNC_STAGES-1];

    // Bring the asynchronous PLL LOCK into the clock domain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // Next-state decision plus retry / lock-loss increment requests.
    always_comb begin
        state_nx_s  = state_r;
        retry_inc_s = 1'b0;
        loss_inc_s  = 1'b0;
        case (state_r)
            ST_PLL_RST: begin
                if (cnt_r == CW'(PLL_RST_CYCLES-1)) begin
                    state_nx_s = ST_WAIT_LOCK;
                end else begin
                    state_nx_s = ST_PLL_RST;
                end
            end
            ST_WAIT_LOCK: begin
                // A lock seen on the timeout cycle takes priority over the retry.
                if (lock_s) begin
                    state_nx_s = ST_STABILIZE;
                end else if (cnt_r == CW'(LOCK_TIMEOUT-1)) begin
                    if (retry_r < RW'(MAX_RETRIES)) begin
                        state_nx_s  = ST_PLL_RST;
                        retry_inc_s = 1'b1;
                    end else begin
                        state_nx_s = ST_FAIL;
                    end
                end else begin
                    state_nx_s = ST_WAIT_LOCK;
                end
            end
            ST_STABILIZE: begin
                // Any low cycle restarts the whole lock wait and stabilization.
                if (!lock_s) begin
                    state_nx_s = ST_WAIT_LOCK;
                end else if (cnt_r == CW'(STABLE_CYCLES-1)) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_STABILIZE;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nx_s = ST_WAIT_LOCK;
                    loss_inc_s = 1'b1;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_FAIL: begin
                state_nx_s = ST_FAIL;
            end
            default: begin
                state_nx_s = ST_PLL_RST;
            end
        endcase
    end

    // Cycle counter: cleared on every transition and parked in RUN/FAIL.
    always_comb begin
        cnt_nx_s = {CW{1'b0}};
        if ((state_nx_s != state_r) || (state_r == ST_RUN) || (state_r == ST_FAIL)) begin
            cnt_nx_s = {CW{1'b0}};
        end else begin
            cnt_nx_s = cnt_r + CW'(1);
        end
    end

    // State, counters and outputs; outputs are registered from the next state
    // so they line up exactly with the state they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_PLL_RST;
            cnt_r     <= {CW{1'b0}};
            retry_r   <= {RW{1'b0}};
            loss_r    <= 8'd0;
            pll_rst_r <= 1'b1;
            sys_rst_r <= 1'b1;
            ready_r   <= 1'b0;
            fail_r    <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            if (retry_inc_s) begin
                retry_r <= retry_r + RW'(1);
            end else begin
                retry_r <= retry_r;
            end
            if (loss_inc_s && (loss_r != 8'hFF)) begin
                loss_r <= loss_r + 8'd1;
            end else begin
                loss_r <= loss_r;
            end
            pll_rst_r <= (state_nx_s == ST_PLL_RST) || (state_nx_s == ST_FAIL);
            sys_rst_r <= (state_nx_s != ST_RUN);
            ready_r   <= (state_nx_s == ST_RUN);
            fail_r    <= (state_nx_s == ST_FAIL);
        end
    end

    assign pll_rst         = pll_rst_r;
    assign sys_rst         = sys_rst_r;
    assign ready           = ready_r;
    assign fail            = fail_r;
    assign lock_loss_count = loss_r;
    assign retry_count     = retry_r;

endmodule
